// File: rtl/aes_pkg.sv
// Shared AES-128 encryption types, constants and byte-level helpers.
package aes_pkg;

  localparam int unsigned NROUNDS = 10;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  localparam logic [0:9][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic byte_t sbox(input byte_t b);
    return SBOX[b];
  endfunction

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Rounds outside 1..10 get a zero constant; only reached by the idle chain.
  function automatic byte_t rcon(input logic [3:0] rnd);
    byte_t r;
    r = 8'h00;
    if (rnd >= 4'd1 && rnd <= 4'd10) r = RCON[rnd - 4'd1];
    return r;
  endfunction

endpackage

// File: rtl/aes_enc_iter_round.sv
// One combinational AES-128 encryption round with on-the-fly key expansion.
module enc_round
  import aes_pkg::*;
(
  input  state_t     state_i,
  input  state_t     rkey_i,
  input  logic [3:0] rnd_i,
  input  logic       last_i,
  output state_t     state_o,
  output state_t     rkey_o
);

  state_t sr;
  state_t mc;
  state_t nk;
  word_t  tmp;
  byte_t  a0, a1, a2, a3;

  always_comb begin
    sr  = '0;
    mc  = '0;
    nk  = '0;
    a0  = '0;
    a1  = '0;
    a2  = '0;
    a3  = '0;
    tmp = {sbox(rkey_i[23:16]), sbox(rkey_i[15:8]), sbox(rkey_i[7:0]), sbox(rkey_i[31:24])}
          ^ {rcon(rnd_i), 24'h000000};
    nk[127:96] = rkey_i[127:96] ^ tmp;
    nk[95:64]  = rkey_i[95:64]  ^ nk[127:96];
    nk[63:32]  = rkey_i[63:32]  ^ nk[95:64];
    nk[31:0]   = rkey_i[31:0]   ^ nk[63:32];

    // SubBytes fused with ShiftRows: row r of column c reads column (c+r) mod 4.
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        sr[127 - 8*(4*c + r) -: 8] = sbox(state_i[127 - 8*(4*((c + r) % 4) + r) -: 8]);
      end
    end

    for (int unsigned c = 0; c < 4; c++) begin
      a0 = sr[127 - 32*c -: 8];
      a1 = sr[119 - 32*c -: 8];
      a2 = sr[111 - 32*c -: 8];
      a3 = sr[103 - 32*c -: 8];
      mc[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      mc[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      mc[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      mc[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end

    state_o = (last_i ? sr : mc) ^ nk;
    rkey_o  = nk;
  end

endmodule

// File: rtl/aes_enc_iter.sv
// Iterative AES-128 encryption core, UNROLL rounds per clock.
// Define AES_ENC_LASTKEY_EN to export the registered round-10 key on last_key.
module aes_enc_iter
  import aes_pkg::*;
#(
  parameter int unsigned UNROLL = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext
`ifdef AES_ENC_LASTKEY_EN
  ,
  output logic [127:0] last_key
`endif
);

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 5) begin : g_bad_unroll
    $error("aes_enc_iter: UNROLL must be 1, 2 or 5");
  end

  fsm_e       state_q, state_d;
  state_t     st_q, st_d;
  state_t     rkey_q, rkey_d;
  state_t     ct_q, ct_d;
  logic [3:0] rnd_q, rnd_d;
  logic       finish;

  state_t st_c  [UNROLL+1];
  state_t key_c [UNROLL+1];

  assign st_c[0]  = st_q;
  assign key_c[0] = rkey_q;

  for (genvar k = 0; k < UNROLL; k++) begin : g_round
    logic [3:0] rnd_k;
    assign rnd_k = rnd_q + 4'(k);
    enc_round u_round (
      .state_i (st_c[k]),
      .rkey_i  (key_c[k]),
      .rnd_i   (rnd_k),
      .last_i  (rnd_k == 4'(NROUNDS)),
      .state_o (st_c[k+1]),
      .rkey_o  (key_c[k+1])
    );
  end

  assign finish = (rnd_q + 4'(UNROLL - 1)) == 4'(NROUNDS);

`ifdef AES_ENC_LASTKEY_EN
  state_t lk_q, lk_d;
  assign last_key = lk_q;
`endif

  always_comb begin
    state_d   = state_q;
    st_d      = st_q;
    rkey_d    = rkey_q;
    rnd_d     = rnd_q;
    ct_d      = ct_q;
`ifdef AES_ENC_LASTKEY_EN
    lk_d      = lk_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid) begin
          st_d    = plaintext ^ key;
          rkey_d  = key;
          rnd_d   = 4'd1;
          state_d = RUN;
        end
      end
      RUN: begin
        st_d   = st_c[UNROLL];
        rkey_d = key_c[UNROLL];
        rnd_d  = rnd_q + 4'(UNROLL);
        if (finish) begin
          ct_d    = st_c[UNROLL];
`ifdef AES_ENC_LASTKEY_EN
          lk_d    = key_c[UNROLL];
`endif
          rnd_d   = 4'd0;
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      st_q    <= '0;
      rkey_q  <= '0;
      ct_q    <= '0;
      rnd_q   <= '0;
`ifdef AES_ENC_LASTKEY_EN
      lk_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      rkey_q  <= rkey_d;
      ct_q    <= ct_d;
      rnd_q   <= rnd_d;
`ifdef AES_ENC_LASTKEY_EN
      lk_q    <= lk_d;
`endif
    end
  end

  assign ciphertext = ct_q;

endmodule

// File: tb/tb_aes_enc_iter.sv
// Directed bench: three cores (UNROLL 1, 2, 5) driven in lockstep with FIPS-197 vectors.
module tb_aes_enc_iter;

  localparam logic [127:0] PT  [2] = '{128'h00112233445566778899aabbccddeeff,
                                       128'h3243f6a8885a308d313198a2e0370734};
  localparam logic [127:0] KEY [2] = '{128'h000102030405060708090a0b0c0d0e0f,
                                       128'h2b7e151628aed2a6abf7158809cf4f3c};
  localparam logic [127:0] CT  [2] = '{128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                                       128'h3925841d02dc09fbdc118597196a0b32};
`ifdef AES_ENC_LASTKEY_EN
  localparam logic [127:0] LK  [2] = '{128'h13111d7fe3944a17f307a78b4d2b30c5,
                                       128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] plaintext;
  logic [127:0] key;
  logic         ir [3];
  logic         ov [3];
  logic [127:0] ct [3];
`ifdef AES_ENC_LASTKEY_EN
  logic [127:0] lk [3];
`endif

  int unsigned npass = 0;
  int unsigned ntot  = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    aes_enc_iter #(.UNROLL(g == 0 ? 1 : (g == 1 ? 2 : 5))) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (ir[g]),
      .plaintext  (plaintext),
      .key        (key),
      .out_valid  (ov[g]),
      .out_ready  (out_ready),
      .ciphertext (ct[g])
`ifdef AES_ENC_LASTKEY_EN
      ,
      .last_key   (lk[g])
`endif
    );
  end

  function automatic int unsigned lat(input int unsigned g);
    return (g == 0) ? 10 : ((g == 1) ? 5 : 2);
  endfunction

  task automatic chk(input string tag, input int unsigned g,
                     input logic [127:0] got, input logic [127:0] exp);
    ntot++;
    assert (got === exp) npass++;
    else $error("FAIL %s u%0d got=%h exp=%h", tag, lat(g), got, exp);
  endtask

  task automatic chk_results(input int unsigned v);
    for (int unsigned g = 0; g < 3; g++) begin
      chk("ciphertext", g, ct[g], CT[v]);
`ifdef AES_ENC_LASTKEY_EN
      chk("last_key", g, lk[g], LK[v]);
`endif
    end
  endtask

  // Drives vector v; hold_rdy keeps out_ready high, poke drives junk in_valid while busy,
  // bp is the number of stalled cycles before the out_ready pulse.
  task automatic run(input int unsigned v, input bit hold_rdy, input bit poke,
                     input int unsigned bp);
    @(negedge clk);
    for (int unsigned g = 0; g < 3; g++) chk("in_ready_idle", g, 128'(ir[g]), 128'd1);
    plaintext = PT[v];
    key       = KEY[v];
    in_valid  = 1'b1;
    out_ready = hold_rdy;
    @(negedge clk);
    in_valid  = poke;
    plaintext = ~PT[v];
    key       = KEY[v] ^ 128'h5a5a5a5a_a5a5a5a5_0f0f0f0f_f0f0f0f0;
    for (int unsigned c = 1; c <= 10; c++) begin
      @(negedge clk);
      for (int unsigned g = 0; g < 3; g++) begin
        chk("out_valid", g, 128'(ov[g]),
            128'(hold_rdy ? (c == lat(g)) : (c >= lat(g))));
        chk("in_ready_busy", g, 128'(ir[g]), 128'(hold_rdy ? (c > lat(g)) : 1'b0));
      end
    end
    in_valid = 1'b0;
    chk_results(v);
    if (hold_rdy) begin
      @(negedge clk);
      out_ready = 1'b0;
      for (int unsigned g = 0; g < 3; g++) chk("out_valid_onecycle", g, 128'(ov[g]), 128'd0);
    end else begin
      for (int unsigned b = 0; b < bp; b++) begin
        @(negedge clk);
        for (int unsigned g = 0; g < 3; g++) begin
          chk("held_ct", g, ct[g], CT[v]);
          chk("held_valid", g, 128'(ov[g]), 128'd1);
          chk("held_ready", g, 128'(ir[g]), 128'd0);
        end
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      for (int unsigned g = 0; g < 3; g++) begin
        chk("valid_drop", g, 128'(ov[g]), 128'd0);
        chk("ready_back", g, 128'(ir[g]), 128'd1);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    plaintext = '0;
    key       = '0;
    repeat (2) @(negedge clk);
    for (int unsigned g = 0; g < 3; g++) begin
      chk("rst_in_ready", g, 128'(ir[g]), 128'd0);
      chk("rst_out_valid", g, 128'(ov[g]), 128'd0);
      chk("rst_ct", g, ct[g], 128'd0);
`ifdef AES_ENC_LASTKEY_EN
      chk("rst_lk", g, lk[g], 128'd0);
`endif
    end
    rst = 1'b0;
    #1;
    for (int unsigned g = 0; g < 3; g++) chk("ready_after_rst", g, 128'(ir[g]), 128'd1);

    run(0, 1'b0, 1'b0, 20);
    run(1, 1'b1, 1'b0, 0);
    run(0, 1'b0, 1'b1, 2);
    run(1, 1'b0, 1'b0, 0);

    @(negedge clk);
    plaintext = PT[0];
    key       = KEY[0];
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid  = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    for (int unsigned g = 0; g < 3; g++) begin
      chk("abort_valid", g, 128'(ov[g]), 128'd0);
      chk("abort_ct", g, ct[g], 128'd0);
      chk("abort_ready", g, 128'(ir[g]), 128'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    for (int unsigned g = 0; g < 3; g++) chk("ready_after_abort", g, 128'(ir[g]), 128'd1);
    run(0, 1'b0, 1'b0, 0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
